// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared arbiter state encoding and default sizing
package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int ARB_N        = 3;
  localparam int ARB_MAX_HOLD = 16;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - round-robin pick: first set req bit at or above ptr, wrapping to 0
module rr_pick
  import arb_pkg::*;
#(
  parameter int N   = ARB_N,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   pick,
  output logic [IDW-1:0] pick_id,
  output logic           pick_vld
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] masked;
  int             first;

  // The upper copy of req provides the wrap-around candidates below ptr.
  always_comb begin
    dbl    = {req, req};
    masked = '0;
    for (int j = 0; j < 2 * N; j++) begin
      masked[j] = dbl[j] && (j >= int'(ptr));
    end
    first = 0;
    for (int j = 2 * N - 1; j >= 0; j--) begin
      if (masked[j]) first = j;
    end
    if (first >= N) first = first - N;
    pick_vld = |req;
    pick_id  = pick_vld ? IDW'(first) : '0;
    pick     = '0;
    if (pick_vld) pick[first] = 1'b1;
  end

endmodule

// File: rtl/rr_hold_arb.sv
// rtl/rr_hold_arb.sv - round-robin arbiter with grant hold; timeout via RR_HOLD_ARB_TIMEOUT_EN
module rr_hold_arb
  import arb_pkg::*;
#(
  parameter int N        = ARB_N,
  parameter int IDW      = $clog2(N),
  parameter int MAX_HOLD = ARB_MAX_HOLD
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic           gnt_vld,
  output logic [IDW-1:0] gnt_id,
  output logic           preempt
);

  arb_state_e     state_q, state_d;
  logic [N-1:0]   gnt_d;
  logic [IDW-1:0] id_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [N-1:0]   pick_req;
  logic [N-1:0]   pick;
  logic [IDW-1:0] pick_id;
  logic           pick_vld;
  logic           owner_req;
  logic           timeout_hit;

  // The current owner is always excluded from the pick, which also covers preemption.
  assign pick_req  = (state_q == BUSY) ? (req & ~gnt) : req;
  assign owner_req = |(req & gnt);

  rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .req      (pick_req),
    .ptr      (ptr_q),
    .pick     (pick),
    .pick_id  (pick_id),
    .pick_vld (pick_vld)
  );

`ifdef RR_HOLD_ARB_TIMEOUT_EN
  localparam int HCW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  logic [HCW-1:0] hold_q, hold_d;
  logic           preempt_q;

  assign timeout_hit = (state_q == BUSY) && owner_req && pick_vld &&
                       (hold_q == HCW'(MAX_HOLD - 1));
  assign preempt     = preempt_q;

  always_comb begin
    hold_d = hold_q;
    if (state_q == IDLE || !owner_req || timeout_hit) begin
      hold_d = '0;
    end else if (hold_q != HCW'(MAX_HOLD - 1)) begin
      hold_d = hold_q + HCW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q    <= '0;
      preempt_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      preempt_q <= timeout_hit;
    end
  end
`else
  logic unused_max_hold;

  assign unused_max_hold = (MAX_HOLD > 0);
  assign timeout_hit     = 1'b0;
  assign preempt         = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt;
    id_d    = gnt_id;
    ptr_d   = ptr_q;
    if (state_q == IDLE || !owner_req || timeout_hit) begin
      if (pick_vld) begin
        state_d = BUSY;
        gnt_d   = pick;
        id_d    = pick_id;
        ptr_d   = (pick_id == IDW'(N - 1)) ? '0 : pick_id + IDW'(1);
      end else begin
        state_d = IDLE;
        gnt_d   = '0;
        id_d    = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt     <= '0;
      gnt_vld <= 1'b0;
      gnt_id  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt     <= gnt_d;
      gnt_vld <= |gnt_d;
      gnt_id  <= id_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: tb/tb_rr_hold_arb.sv
// tb/tb_rr_hold_arb.sv - directed self-checking bench for rr_hold_arb (N=3, MAX_HOLD=4)
module tb_rr_hold_arb;

  localparam int N   = 3;
  localparam int IDW = 2;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N-1:0]   gnt;
  logic           gnt_vld;
  logic [IDW-1:0] gnt_id;
  logic           preempt;

  int n_checks;
  int n_fail;

  rr_hold_arb #(.N(N), .IDW(IDW), .MAX_HOLD(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt     (gnt),
    .gnt_vld (gnt_vld),
    .gnt_id  (gnt_id),
    .preempt (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_gnt(input string tag, input logic [N-1:0] g, input logic [IDW-1:0] id,
                            input logic pre);
    check({tag, ".gnt"}, 32'(gnt), 32'(g));
    check({tag, ".vld"}, 32'(gnt_vld), 32'(|g));
    check({tag, ".id"}, 32'(gnt_id), 32'(id));
    check({tag, ".pre"}, 32'(preempt), 32'(pre));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    req      = '0;
    step();
    step();
    expect_gnt("reset", 3'b000, 2'd0, 1'b0);
    rst_n = 1'b1;

    // All request: requester 0 wins and holds against toggling neighbours.
    req = 3'b111;
    step();
    expect_gnt("first", 3'b001, 2'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      req = {2'($urandom_range(0, 3)), 1'b1};
      step();
      check("hold0.gnt", 32'(gnt), 32'h1);
    end

    req = 3'b110;
    step();
    expect_gnt("to1", 3'b010, 2'd1, 1'b0);
    req = 3'b100;
    step();
    expect_gnt("to2", 3'b100, 2'd2, 1'b0);
    req = 3'b001;
    step();
    expect_gnt("wrap0", 3'b001, 2'd0, 1'b0);

    // A requester that drops before its grant is never granted.
    req = 3'b011;
    step();
    req = 3'b001;
    step();
    check("drop_early.gnt", 32'(gnt), 32'h1);

    req = 3'b010;
    step();
    expect_gnt("own1", 3'b010, 2'd1, 1'b0);
    req = 3'b000;
    step();
    expect_gnt("idle", 3'b000, 2'd0, 1'b0);
    req = 3'b001;
    step();
    expect_gnt("idle_to0", 3'b001, 2'd0, 1'b0);

    // Same-cycle release and re-request of bit 0 loses to requester 2.
    req = 3'b100;
    step();
    expect_gnt("own2", 3'b100, 2'd2, 1'b0);

    // Asynchronous reset mid-tenure.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst.gnt", 32'(gnt), 32'h0);
    check("async_rst.vld", 32'(gnt_vld), 32'h0);
    step();
    rst_n = 1'b1;
    req   = 3'b111;
    step();
    expect_gnt("ptr_reset", 3'b001, 2'd0, 1'b0);

    // Fresh reset before the hold-limit scenario so counting starts clean.
    rst_n = 1'b0;
    req   = 3'b000;
    step();
    rst_n = 1'b1;
    req   = 3'b011;
    step();
    expect_gnt("to_c1", 3'b001, 2'd0, 1'b0);
    step();
    step();
    step();
    expect_gnt("to_c4", 3'b001, 2'd0, 1'b0);
    step();
`ifdef RR_HOLD_ARB_TIMEOUT_EN
    expect_gnt("to_c5", 3'b010, 2'd1, 1'b1);
    step();
    expect_gnt("to_c6", 3'b010, 2'd1, 1'b0);
    step();
    step();
    expect_gnt("to_c8", 3'b010, 2'd1, 1'b0);
    step();
    expect_gnt("to_c9", 3'b001, 2'd0, 1'b1);
`else
    expect_gnt("nto_c5", 3'b001, 2'd0, 1'b0);
    step();
    step();
    step();
    step();
    expect_gnt("nto_c9", 3'b001, 2'd0, 1'b0);
`endif

    // Lone owner keeps the grant past the hold limit.
    req = 3'b001;
    for (int i = 0; i < 10; i++) begin
      step();
      check("solo.gnt", 32'(gnt), 32'h1);
      check("solo.pre", 32'(preempt), 32'h0);
    end

    req = 3'b000;
    step();
    expect_gnt("final_idle", 3'b000, 2'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_hold_arb.md
Name: rr_hold_arb

Overview:
- Round-robin arbiter with grant hold, for a single shared resource used by N requesters.
- A requester keeps the grant for as long as it holds req high; ownership changes only on release.
- Sits in front of the shared resource, next to the existing fixed-priority arbiter.
- Replaces fixed priority where starvation of low-index requesters is not acceptable.

Parameters:
- N, 3, number of requesters (N >= 2).
- IDW, $clog2(N), width of gnt_id and of the priority pointer.
- MAX_HOLD, 16, hold-cycle limit; used only when RR_HOLD_ARB_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  N  request vector, level; bit i high = requester i wants or is using the resource.
- gnt  out  N  registered one-hot grant; all zeros when idle.
- gnt_vld  out  1  high when any grant is active (OR of gnt, registered).
- gnt_id  out  IDW  binary index of the granted requester; 0 when idle.
- preempt  out  1  one-cycle pulse when a grant is revoked by timeout; constant 0 without the macro.

Behaviour:
- Single clock domain.
- Reset (async assert, sync deassert by system) gives: gnt=0, gnt_vld=0, gnt_id=0, preempt=0, ptr=0, hold_cnt=0, state=IDLE.
- States:
  - IDLE: no owner. If req != 0, the pick is the first set bit searching from ptr upward with wrap to 0. Next cycle: gnt=onehot(pick), gnt_id=pick, ptr=(pick+1) mod N, state=BUSY. If req == 0, stay in IDLE.
  - BUSY: owner k. While req[k]=1, hold gnt unchanged, whatever other req bits do. When req[k]=0 at cycle t, re-arbitrate in the same cycle over req (bit k is naturally 0). At t+1, gnt shows the new owner, or 0 with state=IDLE if no other requests. There is no bubble cycle between owners.
- Latency: request to grant is 1 cycle when idle. Release to next grant is 1 cycle.
- Fairness: ptr always points one past the last winner, so no requester waits more than N-1 tenures.
- Wrap: ptr=N-1 followed by a grant to N-1 sets ptr=0. ptr never holds a value >= N.
- Simultaneous release and new request on the same bit: the released bit is low that cycle, so it cannot win. It is eligible again from the next cycle with lowest priority.
- A requester that drops req before its grant arrives is never granted.
- Reset mid-grant: gnt drops asynchronously to 0 and ptr returns to 0.
- gnt, gnt_vld and gnt_id are mutually consistent every cycle. They are driven directly by flops, with no combinational path from req to outputs.

Optional Feature:
- Macro: RR_HOLD_ARB_TIMEOUT_EN.
- Defined:
  - hold_cnt counts BUSY cycles of the current owner and clears on every owner change.
  - When hold_cnt == MAX_HOLD-1, and any other req bit is high, and req[k] is still 1: revoke the grant. Next cycle, gnt goes to the round-robin pick over req with bit k masked, and preempt=1 for that one cycle.
  - The preempted requester keeps req high and competes again normally, at lowest priority.
  - With no other requesters, the owner keeps the grant and hold_cnt saturates.
- Not defined: no counter logic, and preempt is tied to 0.

Decomposition:
- Shared package arb_pkg holds:
  - State encoding: IDLE=1'b0, BUSY=1'b1.
  - The default N and MAX_HOLD constants, shared with the fixed-priority arbiter.
- One natural sub-module, rr_pick: combinational, takes (req, ptr), returns a one-hot pick, the binary index and an any-valid flag. It is implemented with a double-width masked priority encode.
- The top level holds the FSM, ptr, hold_cnt and the output registers.

Test Plan (N=3, MAX_HOLD=4):
- Reset, then req=3'b111 at cycle 0 -> gnt=3'b001, gnt_id=0 at cycle 1; it holds while req[0]=1 over 5 cycles, with other bits toggling randomly.
- From the previous state, drop req[0] (req=3'b110) -> next cycle gnt=3'b010. Drop req[1] -> gnt=3'b100. Drop req[2] with req[0] re-raised -> gnt=3'b001 (wrap).
- Owner 1 releases with req=3'b000 -> gnt=0, gnt_vld=0, gnt_id=0. Then req=3'b001 -> gnt=3'b001 one cycle later.
- Assert rst_n=0 mid-tenure with gnt=3'b100 -> gnt=0 immediately, with no clock needed. After release with req=3'b111 -> gnt=3'b001 (ptr reset to 0).
- Timeout macro defined, owner 0 holding and req=3'b011 constant -> after 4 BUSY cycles gnt=3'b010 with preempt=1 for 1 cycle. If req[1] is then held, gnt returns to 3'b001 after 4 more cycles.
- Timeout macro defined, req=3'b001 only for 10 cycles -> gnt stays 3'b001 and preempt stays 0.
